// File: rtl/aemb_pkg.sv
// Shared AEMB definitions: fetch FSM encoding, default reset vector, NOP word.
package aemb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] AEMB_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] AEMB_NOP       = 32'h8800_0000;
  localparam int unsigned AEMB_IFIFO_W   = 64;

  function automatic logic [31:0] wordAlign(input logic [31:0] adr);
    return {adr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/aemb_ififo.sv
// Prefetch FIFO of {pc, data} entries; clear wins over push, push+pop legal when full.
module aemb_ififo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             gclk,
  input  logic             grst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr, wrPtr;
  logic [CW-1:0]    rCnt;
  logic             doPush, doPop;

  assign full   = (rCnt == CW'(DEPTH));
  assign empty  = (rCnt == '0);
  assign count  = rCnt;
  assign dout   = mem[rdPtr];
  assign doPush = push & ~clear & (~full | pop);
  assign doPop  = pop & ~empty & ~clear;

  always_ff @(posedge gclk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  always_ff @(posedge gclk) begin
    if (grst || clear) begin
      rdPtr <= '0;
      wrPtr <= '0;
      rCnt  <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      unique case ({doPush, doPop})
        2'b10:   rCnt <= rCnt + CW'(1);
        2'b01:   rCnt <= rCnt - CW'(1);
        default: rCnt <= rCnt;
      endcase
    end
  end

endmodule

// File: rtl/aemb_ifetch.sv
// AEMB instruction fetch: fetch PC, Wishbone master, prefetch FIFO, branch redirect.
// Optional same-cycle ack forwarding when AEMB_IFETCH_BYPASS_EN is defined.
module aemb_ifetch
  import aemb_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = AEMB_RESET_VEC
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        gena,
  input  logic        rBRA,
  input  logic [31:0] rBRA_TGT,
  output logic [29:0] iwb_adr_o,
  output logic        iwb_stb_o,
  input  logic        iwb_ack_i,
  input  logic [31:0] iwb_dat_i,
  output logic [31:0] if_dat_o,
  output logic [31:0] if_pc_o,
  output logic        if_vld_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  rState, rNext;
  logic [31:0]   rFPC;
  logic [31:0]   rHoldPc, rHoldDat;
  logic          redirect, take, fetchAck, bypass;
  logic          fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [CW-1:0] fifoCnt;
  logic [63:0]   fifoHead;

  assign redirect  = rBRA & gena;
  assign take      = gena & ~rBRA;
  assign iwb_stb_o = (rState == FETCH) && (fifoCnt < CW'(DEPTH));
  assign iwb_adr_o = rFPC[31:2];
  assign fetchAck  = iwb_stb_o & iwb_ack_i & ~redirect;

`ifdef AEMB_IFETCH_BYPASS_EN
  assign bypass = fetchAck & fifoEmpty;
`else
  assign bypass = 1'b0;
`endif

  // A forwarded word the consumer takes this cycle never enters the FIFO.
  assign fifoPop  = take & ~fifoEmpty;
  assign fifoPush = fetchAck & ~(bypass & take) & (~fifoFull | fifoPop);

  assign if_vld_o = ~fifoEmpty | bypass;

  always_comb begin
    if_dat_o = rHoldDat;
    if_pc_o  = rHoldPc;
    if (!fifoEmpty) begin
      if_pc_o  = fifoHead[63:32];
      if_dat_o = fifoHead[31:0];
    end else if (bypass) begin
      if_pc_o  = rFPC;
      if_dat_o = iwb_dat_i;
    end
  end

  always_comb begin
    rNext = rState;
    unique case (rState)
      IDLE:    rNext = FETCH;
      FETCH:   rNext = FETCH;
      FLUSH:   rNext = FETCH;
      default: rNext = IDLE;
    endcase
    if (redirect) rNext = FLUSH;
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      rState   <= IDLE;
      rFPC     <= RESET_VEC;
      rHoldPc  <= '0;
      rHoldDat <= '0;
    end else begin
      rState <= rNext;
      if (redirect)      rFPC <= wordAlign(rBRA_TGT);
      else if (fetchAck) rFPC <= rFPC + 32'd4;
      if (if_vld_o) begin
        rHoldPc  <= if_pc_o;
        rHoldDat <= if_dat_o;
      end
    end
  end

  aemb_ififo #(
    .DEPTH (DEPTH),
    .WIDTH (AEMB_IFIFO_W)
  ) u_fifo (
    .gclk  (gclk),
    .grst  (grst),
    .push  (fifoPush),
    .pop   (fifoPop),
    .clear (redirect),
    .din   ({rFPC, iwb_dat_i}),
    .dout  (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCnt)
  );

endmodule

// File: doc/aemb_ifetch.md
Name: aemb_ifetch

Overview:
Instruction fetch stage feeding the AEMB instruction buffer. It owns the fetch PC and masters the instruction Wishbone bus. A small prefetch FIFO decouples bus latency from pipeline stalls, and the block presents one instruction plus its PC to the buffer stage. Taken branches flush the FIFO and redirect the fetch PC.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of 2, range 2..16
RESET_VEC, 32'h00000000, fetch PC after reset; must be word aligned

Ports:
gclk  in  1  system clock, all logic on posedge
grst  in  1  synchronous active-high reset
gena  in  1  pipeline advance; consumer accepts head instruction this cycle
rBRA  in  1  branch taken, qualified by gena
rBRA_TGT  in  32  branch target byte address; bits [1:0] ignored
iwb_adr_o  out  30  word address of current fetch (PC[31:2])
iwb_stb_o  out  1  Wishbone strobe (doubles as cyc)
iwb_ack_i  in  1  Wishbone acknowledge
iwb_dat_i  in  32  Wishbone read data
if_dat_o  out  32  instruction at FIFO head
if_pc_o  out  32  byte PC of if_dat_o
if_vld_o  out  1  if_dat_o/if_pc_o valid (FIFO non-empty)

Behaviour:
- Reset: fetch PC rFPC=RESET_VEC, state=IDLE, FIFO count=0, iwb_stb_o=0, if_vld_o=0, if_dat_o=0, if_pc_o=0.
- States: IDLE, FETCH, FLUSH.
- IDLE -> FETCH one cycle after grst deasserts. No strobe in IDLE.
- FETCH: iwb_stb_o=1 when count<DEPTH, else 0. iwb_adr_o=rFPC[31:2], held stable until ack.
- Ack in FETCH, no redirect: push {rFPC, iwb_dat_i}; rFPC+=4 (wraps 32'hFFFFFFFC -> 0).
- Redirect = rBRA & gena. Effects the same cycle: FIFO cleared; rFPC<=rBRA_TGT&~3; state -> FLUSH. Any ack in this cycle is discarded.
- FLUSH: iwb_stb_o=0 for exactly one cycle, which abandons the in-flight cycle; any ack during FLUSH is discarded. Then -> FETCH.
- Redirect during FLUSH: reload rFPC, stay in FLUSH one more cycle.
- Pop: gena & if_vld_o & !rBRA removes the head.
- Simultaneous push and pop: count unchanged; the new entry follows existing entries in order.
- Full: stb stays low until a pop. A pop while full permits stb on the next cycle, not the same one.
- Ack with stb low: ignored.
- Latency: ack -> if_vld_o/if_dat_o is 1 cycle (registered FIFO head). Redirect -> first target fetch strobe is 2 cycles.
- if_dat_o/if_pc_o hold their last value when empty; consumers use if_vld_o.
- gena low: no pops and no redirects; fetching continues until full.
- grst mid-operation: overrides everything and returns all state to reset values.

Optional Feature:
AEMB_IFETCH_BYPASS_EN
- Defined: when the FIFO is empty and an ack arrives in FETCH, iwb_dat_i and rFPC are forwarded combinationally to if_dat_o/if_pc_o, with if_vld_o=1 the same cycle.
  - If gena & !rBRA in that cycle, the word is consumed and not pushed.
  - Otherwise it is pushed normally.
  - Ack-to-use latency becomes 0.
- Undefined: purely registered outputs, 1-cycle latency as above.

Decomposition:
- Shared package aemb_pkg:
  - fetch state encoding (IDLE=2'd0, FETCH=2'd1, FLUSH=2'd2)
  - default RESET_VEC
  - AEMB NOP constant 32'h88000000
- Sub-module aemb_ififo: synchronous FIFO, width 64 ({pc,data}), DEPTH entries.
  - Ports: push, pop, clear, full, empty, count.
  - Pop and push allowed in the same cycle when full; clear has priority over push.
- aemb_ifetch holds the PC, the FSM and the Wishbone control.

Test Plan:
- Reset release, ack every cycle, gena=1 -> iwb_adr_o 0,1,2,...; if_pc_o 0,4,8 in order; if_vld_o high from the second ack onward.
- gena=0, ack always, DEPTH=4 -> exactly 4 pushes, then iwb_stb_o=0 and iwb_adr_o holds 4. Raise gena -> stb returns the cycle after the first pop.
- Branch rBRA=1, gena=1, rBRA_TGT=32'h00000103 with ack coincident -> ack discarded, FIFO empty, stb low for 1 cycle, then iwb_adr_o=30'h40; next if_pc_o=32'h100.
- Ack wait states (ack every 3rd cycle) -> iwb_adr_o stable while stb high; no duplicate or skipped PCs.
- Back-to-back redirects in consecutive cycles to 0x200 then 0x300 -> the only fetch issued is 0x300>>2; no entry from 0x200 ever appears.
- With AEMB_IFETCH_BYPASS_EN, empty FIFO, ack data 32'hB9CE0010 -> if_dat_o=32'hB9CE0010 with if_vld_o=1 in the ack cycle; FIFO count stays 0 when gena=1.
